// File: rtl/hc595_chain_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : hc595_chain_ctrl_if
// Description : Word handshake and frame status between scan logic and the
//               74HC595 chain driver.
// Revision    : 1.0 - initial release
// ============================================================================
interface hc595_chain_ctrl_if #(
  parameter int DATA_W = 14
) ();
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              din_ready;
  logic              busy;
  logic              frame_done;

  // Producer of words (display / scan logic)
  modport master (
    output din, din_valid,
    input  din_ready, busy, frame_done
  );

  // Chain driver
  modport slave (
    input  din, din_valid,
    output din_ready, busy, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/hc595_chain_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hc595_chain_ctrl
// Description : Serial driver for a cascade of 74HC595 shift registers.
//               Accepts a DATA_W-bit word over valid/ready, shifts it out on
//               ds/shcp at 2*CLK_DIV sys_clk cycles per bit, then pulses stcp
//               for CLK_DIV cycles to latch it.
//               Optional macro HC595_PWM_DIM_EN adds a bright[7:0] input that
//               PWM-dims the chain through oe.
// Revision    : 1.0 - initial release
// ============================================================================
module hc595_chain_ctrl #(
  parameter int DATA_W    = 14,
  parameter int CLK_DIV   = 2,
  parameter bit LSB_FIRST = 1'b0
) (
  input  wire logic         sys_clk,
  input  wire logic         sys_rst_n,
  hc595_chain_ctrl_if.slave bus,
`ifdef HC595_PWM_DIM_EN
  input  wire logic [7:0]   bright,
`endif
  output logic              stcp,
  output logic              shcp,
  output logic              ds,
  output logic              oe
);

  localparam int c_BIT_W = $clog2(DATA_W + 1);
  localparam int c_PH_W  = $clog2(2 * CLK_DIV);

  localparam logic [c_BIT_W-1:0] c_BIT_LAST   = c_BIT_W'(DATA_W - 1);
  localparam logic [c_PH_W-1:0]  c_PH_LAST    = c_PH_W'(2 * CLK_DIV - 1);
  localparam logic [c_PH_W-1:0]  c_PH_HALF    = c_PH_W'(CLK_DIV);
  localparam logic [c_PH_W-1:0]  c_LATCH_LAST = c_PH_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  state_t              r_state;
  logic [c_BIT_W-1:0]  r_bit;
  logic [c_PH_W-1:0]   r_phase;
  logic [DATA_W-1:0]   r_shadow;
  logic                r_stcp;
  logic                r_shcp;
  logic                r_ds;
  logic                r_busy;
  logic                r_done;

  logic [c_PH_W-1:0]   w_ph_next;
  logic                w_first_bit;
  logic                w_next_bit;
  logic [DATA_W-1:0]   w_first_rest;
  logic [DATA_W-1:0]   w_next_rest;

  assign w_ph_next = r_phase + c_PH_W'(1);

  // The shadow register is kept pre-shifted so the next bit to send always
  // sits at a fixed end; the first bit goes straight from din to ds.
  generate
    if (LSB_FIRST) begin : g_lsb_first
      assign w_first_bit  = bus.din[0];
      assign w_first_rest = bus.din >> 1;
      assign w_next_bit   = r_shadow[0];
      assign w_next_rest  = r_shadow >> 1;
    end else begin : g_msb_first
      assign w_first_bit  = bus.din[DATA_W-1];
      assign w_first_rest = bus.din << 1;
      assign w_next_bit   = r_shadow[DATA_W-1];
      assign w_next_rest  = r_shadow << 1;
    end
  endgenerate

  // Frame sequencer: every output is registered one cycle ahead of its slot
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state  <= ST_IDLE;
      r_bit    <= '0;
      r_phase  <= '0;
      r_shadow <= '0;
      r_stcp   <= 1'b0;
      r_shcp   <= 1'b0;
      r_ds     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_shcp <= 1'b0;
          r_stcp <= 1'b0;
          if (bus.din_valid) begin
            r_state  <= ST_SHIFT;
            r_bit    <= '0;
            r_phase  <= '0;
            r_ds     <= w_first_bit;
            r_shadow <= w_first_rest;
            r_busy   <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (r_phase == c_PH_LAST) begin
            r_phase <= '0;
            r_shcp  <= 1'b0;
            if (r_bit == c_BIT_LAST) begin
              r_state <= ST_LATCH;
              r_stcp  <= 1'b1;
              r_done  <= (CLK_DIV == 1);
            end else begin
              r_bit    <= r_bit + c_BIT_W'(1);
              r_ds     <= w_next_bit;
              r_shadow <= w_next_rest;
            end
          end else begin
            r_phase <= w_ph_next;
            r_shcp  <= (w_ph_next >= c_PH_HALF);
          end
        end
        ST_LATCH: begin
          if (r_phase == c_LATCH_LAST) begin
            r_state <= ST_IDLE;
            r_phase <= '0;
            r_stcp  <= 1'b0;
            r_busy  <= 1'b0;
          end else begin
            r_phase <= w_ph_next;
            r_done  <= (w_ph_next == c_LATCH_LAST);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_phase <= '0;
          r_stcp  <= 1'b0;
          r_shcp  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.din_ready  = (r_state == ST_IDLE) & sys_rst_n;
  assign bus.busy       = r_busy;
  assign bus.frame_done = r_done;
  assign stcp           = r_stcp;
  assign shcp           = r_shcp;
  assign ds             = r_ds;

`ifdef HC595_PWM_DIM_EN
  logic [7:0] r_pwm_cnt;
  logic [7:0] r_bright;

  // Free-running PWM period; brightness only changes at a period boundary
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_pwm_cnt <= 8'd0;
      r_bright  <= 8'd0;
    end else begin
      if (r_pwm_cnt == 8'hFF) begin
        r_pwm_cnt <= 8'd0;
        r_bright  <= bright;
      end else begin
        r_pwm_cnt <= r_pwm_cnt + 8'd1;
      end
    end
  end

  assign oe = ~sys_rst_n | (r_pwm_cnt >= r_bright);
`else
  assign oe = ~sys_rst_n;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hc595_chain_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hc595_chain_ctrl
// Description : Self-checking bench for hc595_chain_ctrl. Three instances:
//               A (14 bits, CLK_DIV 2, MSB first), B (same, LSB first) and
//               C (1 bit, CLK_DIV 1). Expected waveforms come from a
//               cycle-indexed model of the frame timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hc595_chain_ctrl;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b1;
  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [13:0] din_drv = 14'd0;
  logic        valid_a = 1'b0;
  logic        valid_b = 1'b0;
  logic        valid_c = 1'b0;
`ifdef HC595_PWM_DIM_EN
  logic [7:0]  bright  = 8'd0;
`endif

  hc595_chain_ctrl_if #(.DATA_W(14)) a_if ();
  hc595_chain_ctrl_if #(.DATA_W(14)) b_if ();
  hc595_chain_ctrl_if #(.DATA_W(1))  c_if ();

  assign a_if.din       = din_drv;
  assign a_if.din_valid = valid_a;
  assign b_if.din       = din_drv;
  assign b_if.din_valid = valid_b;
  assign c_if.din       = din_drv[0];
  assign c_if.din_valid = valid_c;

  logic a_stcp, a_shcp, a_ds, a_oe;
  logic b_stcp, b_shcp, b_ds, b_oe;
  logic c_stcp, c_shcp, c_ds, c_oe;

  hc595_chain_ctrl #(.DATA_W(14), .CLK_DIV(2), .LSB_FIRST(1'b0)) u_a (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(a_if),
`ifdef HC595_PWM_DIM_EN
    .bright(bright),
`endif
    .stcp(a_stcp), .shcp(a_shcp), .ds(a_ds), .oe(a_oe)
  );

  hc595_chain_ctrl #(.DATA_W(14), .CLK_DIV(2), .LSB_FIRST(1'b1)) u_b (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(b_if),
`ifdef HC595_PWM_DIM_EN
    .bright(bright),
`endif
    .stcp(b_stcp), .shcp(b_shcp), .ds(b_ds), .oe(b_oe)
  );

  hc595_chain_ctrl #(.DATA_W(1), .CLK_DIV(1), .LSB_FIRST(1'b0)) u_c (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(c_if),
`ifdef HC595_PWM_DIM_EN
    .bright(bright),
`endif
    .stcp(c_stcp), .shcp(c_shcp), .ds(c_ds), .oe(c_oe)
  );

  // Observed bundle of the selected instance: {ds, shcp, stcp, done, busy, ready}
  int         sel = 0;
  logic [5:0] obs;
  logic       obs_oe;
  always_comb begin
    obs    = 6'd0;
    obs_oe = 1'b0;
    case (sel)
      0: begin
        obs    = {a_ds, a_shcp, a_stcp, a_if.frame_done, a_if.busy, a_if.din_ready};
        obs_oe = a_oe;
      end
      1: begin
        obs    = {b_ds, b_shcp, b_stcp, b_if.frame_done, b_if.busy, b_if.din_ready};
        obs_oe = b_oe;
      end
      default: begin
        obs    = {c_ds, c_shcp, c_stcp, c_if.frame_done, c_if.busy, c_if.din_ready};
        obs_oe = c_oe;
      end
    endcase
  end

  int stcp_rises_a = 0;
  always @(posedge a_stcp) stcp_rises_a <= stcp_rises_a + 1;

  task automatic set_valid(input int s, input logic v);
    valid_a = (s == 0) ? v : 1'b0;
    valid_b = (s == 1) ? v : 1'b0;
    valid_c = (s == 2) ? v : 1'b0;
  endtask

  // Accepts the word currently on din_drv and checks every cycle of the frame
  // against the timing model. hold=1 keeps din_valid high with din changing
  // every cycle; otherwise din_valid is randomly toggled while busy.
  task automatic run_frame(input int s, input int dw, input int cd, input int lsb,
                           input bit hold, input string tag);
    logic [13:0] word;
    logic [5:0]  exp;
    logic        last_bit;
    logic        prev_shcp;
    int          nb, len, k, p, rises;
    sel  = s;
    nb   = dw * 2 * cd;
    len  = nb + cd + 1;
    word = din_drv;
    #1;
    n_checks++;
    if (obs[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL %s accept_ready: din_ready=%b required 1", tag, obs[0]);
    end
    set_valid(s, 1'b1);
    @(posedge sys_clk);
    #1;
    if (!hold) begin
      set_valid(s, 1'b0);
      din_drv = 14'($urandom);
    end
    last_bit  = (lsb != 0) ? word[dw-1] : word[0];
    rises     = 0;
    prev_shcp = 1'b0;
    for (int n = 1; n <= len; n++) begin
      @(negedge sys_clk);
      if (n <= nb) begin
        k   = (n - 1) / (2 * cd);
        p   = (n - 1) % (2 * cd);
        exp = {((lsb != 0) ? word[k] : word[dw-1-k]), (p >= cd), 1'b0, 1'b0, 1'b1, 1'b0};
      end else if (n < len) begin
        exp = {last_bit, 1'b0, 1'b1, (n == len - 1), 1'b1, 1'b0};
      end else begin
        exp = {last_bit, 5'b00001};
      end
      if (obs[4] && !prev_shcp) rises++;
      prev_shcp = obs[4];
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL %s cycle %0d: {ds,shcp,stcp,done,busy,ready}=%b required %b",
                 tag, n, obs, exp);
      end
`ifndef HC595_PWM_DIM_EN
      n_checks++;
      if (obs_oe !== 1'b0) begin
        n_fail++;
        $display("FAIL %s oe cycle %0d: oe=%b required 0", tag, n, obs_oe);
      end
`endif
      if (n < len) begin
        din_drv = 14'($urandom);
        if (!hold) set_valid(s, 1'($urandom));
      end else if (hold) begin
        din_drv = 14'($urandom);
      end else begin
        set_valid(s, 1'b0);
      end
    end
    n_checks++;
    if (rises !== dw) begin
      n_fail++;
      $display("FAIL %s shcp_rises: got %0d required %0d", tag, rises, dw);
    end
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b1;
    #1 sys_rst_n = 1'b0;
    #1;
    n_checks++;
    if ({a_stcp, a_shcp, a_ds, a_oe, a_if.busy, a_if.frame_done, a_if.din_ready} !== 7'b0001000) begin
      n_fail++;
      $display("FAIL reset_a: {stcp,shcp,ds,oe,busy,done,ready}=%b required 0001000",
               {a_stcp, a_shcp, a_ds, a_oe, a_if.busy, a_if.frame_done, a_if.din_ready});
    end
    n_checks++;
    if ({c_stcp, c_shcp, c_ds, c_oe, c_if.busy, c_if.frame_done, c_if.din_ready} !== 7'b0001000) begin
      n_fail++;
      $display("FAIL reset_c: {stcp,shcp,ds,oe,busy,done,ready}=%b required 0001000",
               {c_stcp, c_shcp, c_ds, c_oe, c_if.busy, c_if.frame_done, c_if.din_ready});
    end
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    #1;
    n_checks++;
    if ({a_if.din_ready, a_if.busy, a_stcp} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_release: {ready,busy,stcp}=%b required 100",
               {a_if.din_ready, a_if.busy, a_stcp});
    end
  endtask

  task automatic test_basic_msb();
    din_drv = 14'h2A5C;
    run_frame(0, 14, 2, 0, 1'b0, "basic_msb");
  endtask

  task automatic test_lsb_first();
    din_drv = 14'h2A5C;
    run_frame(1, 14, 2, 1, 1'b0, "lsb_first");
  endtask

  task automatic test_random_frames();
    for (int i = 0; i < 3; i++) begin
      din_drv = 14'($urandom);
      run_frame(0, 14, 2, 0, 1'b0, "rand_msb");
      din_drv = 14'($urandom);
      run_frame(1, 14, 2, 1, 1'b0, "rand_lsb");
    end
  endtask

  task automatic test_back_to_back();
    din_drv = 14'($urandom);
    for (int f = 0; f < 3; f++) run_frame(0, 14, 2, 0, 1'b1, "back_to_back");
    set_valid(0, 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    int base;
    sel     = 0;
    din_drv = 14'($urandom);
    base    = stcp_rises_a;
    set_valid(0, 1'b1);
    @(posedge sys_clk);
    #1 set_valid(0, 1'b0);
    repeat (30) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    n_checks++;
    if ({a_stcp, a_shcp, a_ds, a_if.busy, a_oe, a_if.din_ready} !== 6'b000010) begin
      n_fail++;
      $display("FAIL midreset_assert: {stcp,shcp,ds,busy,oe,ready}=%b required 000010",
               {a_stcp, a_shcp, a_ds, a_if.busy, a_oe, a_if.din_ready});
    end
    repeat (4) @(negedge sys_clk);
    n_checks++;
    if ({a_stcp, a_shcp, a_ds, a_if.busy, a_oe} !== 5'b00001) begin
      n_fail++;
      $display("FAIL midreset_hold: {stcp,shcp,ds,busy,oe}=%b required 00001",
               {a_stcp, a_shcp, a_ds, a_if.busy, a_oe});
    end
    sys_rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);
    n_checks++;
    if ({a_if.din_ready, a_if.busy, a_stcp} !== 3'b100) begin
      n_fail++;
      $display("FAIL midreset_release: {ready,busy,stcp}=%b required 100",
               {a_if.din_ready, a_if.busy, a_stcp});
    end
    n_checks++;
    if (stcp_rises_a !== base) begin
      n_fail++;
      $display("FAIL midreset_no_latch: stcp rises=%0d required %0d", stcp_rises_a, base);
    end
    din_drv = 14'($urandom);
    run_frame(0, 14, 2, 0, 1'b0, "post_reset");
  endtask

  task automatic test_min_width();
    din_drv = 14'h0001;
    run_frame(2, 1, 1, 0, 1'b0, "min_w_one");
    din_drv = 14'h0000;
    run_frame(2, 1, 1, 0, 1'b0, "min_w_zero");
    for (int i = 0; i < 4; i++) begin
      din_drv = 14'($urandom);
      run_frame(2, 1, 1, 0, 1'b0, "min_w_rand");
    end
  endtask

  task automatic test_pwm_dim();
    int lows;
`ifdef HC595_PWM_DIM_EN
    logic [7:0] levels [3];
    levels[0] = 8'd64;
    levels[1] = 8'd0;
    levels[2] = 8'd255;
    for (int j = 0; j < 3; j++) begin
      bright = levels[j];
      repeat (600) @(negedge sys_clk);
      lows = 0;
      for (int i = 0; i < 256; i++) begin
        @(negedge sys_clk);
        if (a_oe === 1'b0) lows++;
      end
      n_checks++;
      if (lows !== int'(levels[j])) begin
        n_fail++;
        $display("FAIL pwm_dim bright=%0d: oe low %0d of 256 required %0d",
                 levels[j], lows, levels[j]);
      end
    end
`else
    lows = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge sys_clk);
      if (a_oe !== 1'b0) lows++;
    end
    n_checks++;
    if (lows !== 0) begin
      n_fail++;
      $display("FAIL oe_static: oe high %0d of 64 idle cycles required 0", lows);
    end
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_msb();
    test_lsb_first();
    test_random_frames();
    test_back_to_back();
    test_reset_mid_frame();
    test_min_width();
    test_pwm_dim();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
